mem_responder: RTL
==================

Name: mem_responder

Overview:
- Responder (target) end of the core's data memory port: mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rmask/mem_rdata.
- Backs the port with a word-organised byte-lane RAM and inserts a fixed, parameterised number of wait states.
- Flags out-of-range and protocol errors.
- Used in simulation benches and as the on-chip data RAM beside the core.

Parameters:
- ADDR_BASE, 32'h0001_0000, byte address of word 0.
- DEPTH_WORDS, 16384, RAM depth in 32-bit words; power of two.
- WAIT_STATES, 2, cycles between request acceptance and mem_ready; 0..15.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- mem_valid  in  1  request present
- mem_instr  in  1  request is a fetch; counted only, no behavioural effect
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write strobes; the core drives nonzero only in the cycle mem_ready is high
- mem_rmask  in  4  byte read mask
- mem_ready  out  1  one-cycle response pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- err  out  1  one-cycle pulse with mem_ready when the access was out of range
- proto_err  out  1  sticky flag: mem_addr changed while a request was in WAIT
- fetch_count  out  32  number of completed accesses with mem_instr=1

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Outputs: mem_ready=0, mem_rdata=0, err=0, proto_err=0, fetch_count=0.
  - State returns to IDLE and the wait counter clears.
  - RAM contents are not cleared.
  - Reset mid-WAIT or in RESP aborts the access and drops any write.
- State machine, one-hot states IDLE, WAIT, RESP:
  - IDLE, mem_valid=0: stay in IDLE.
  - IDLE, mem_valid=1: accept the request.
    - Latch word address addr_q = (mem_addr - ADDR_BASE) >> 2, plus in_range_q, instr_q and rmask_q.
    - Load cnt = WAIT_STATES.
    - Go to WAIT if WAIT_STATES>0, else go to RESP.
  - WAIT: decrement cnt; go to RESP when cnt reaches 1.
  - RESP: mem_ready=1 for exactly this cycle, then go to IDLE unconditionally.
- Latency: a request accepted at edge t gives mem_ready high in cycle t+1+WAIT_STATES.
- Back-to-back: if mem_valid is still 1 in the IDLE cycle after RESP, it is a new request. Minimum spacing between ready pulses is WAIT_STATES+2 cycles.
- Read data:
  - Captured into the mem_rdata register on entry to RESP from RAM[addr_q].
  - Byte lanes with rmask_q bit = 0 are driven 0.
  - Out-of-range accesses return 0.
  - mem_rdata returns to 0 in the cycle after RESP.
- Write:
  - Performed at the edge ending RESP, for each lane i with mem_wstrb[i]=1, into RAM[addr_q].
  - mem_wstrb is sampled only in RESP; nonzero strobes in other states are ignored.
  - Out-of-range writes are dropped.
  - A read of the same word in the next access returns the new data.
- Range check: in range when ADDR_BASE <= mem_addr < ADDR_BASE + 4*DEPTH_WORDS. Compute the subtraction in 33 bits so addresses below ADDR_BASE do not wrap into range.
- err: equals ~in_range_q in RESP, 0 otherwise.
- proto_err: set when state=WAIT and mem_addr != the latched byte address. Cleared only by reset.
- fetch_count: incremented in RESP when instr_q=1; wraps modulo 2^32.
- mem_valid dropping during WAIT or RESP: the access still completes; mem_ready pulses regardless.
- No combinational path from any input to mem_ready.

Decomposition:
- Shared package mem_pkg holds:
  - state encoding constants for IDLE, WAIT, RESP;
  - lane-mask helper: 4-bit mask expanded to a 32-bit byte mask;
  - default ADDR_BASE, which matches the core's PROGADDR_RESET.
- One sub-module, bytelane_ram: DEPTH_WORDS x 32 with a synchronous read port and a 4-lane write-enable port. mem_responder instantiates it and owns the FSM, range check and counters.

Test Plan:
- WAIT_STATES=2: read at 0x0001_0000 with rmask=4'hF, RAM preloaded with 0xDEADBEEF. Request accepted at edge 0 gives mem_ready only in cycle 3, mem_rdata=0xDEADBEEF, err=0.
- Write to 0x0001_0004 with wdata=0x11223344 and wstrb=4'b0101 in RESP, word previously 0xAAAAAAAA. The following read with rmask=4'hF returns 0xAA22AA44.
- Read at 0x0000_FFFC (below base) and at 0x0001_0000+4*DEPTH_WORDS: both give mem_ready with err=1 and mem_rdata=0. A write to the same address leaves RAM unchanged.
- rmask=4'b1100 on a word holding 0x12345678 gives mem_rdata=0x12340000.
- mem_valid held high across two accesses with WAIT_STATES=0: ready pulses in cycles 1 and 3. Change mem_addr during WAIT with WAIT_STATES=3: proto_err=1 and stays 1 until reset.
- Assert resetn=0 during WAIT of a write: no ready pulse, RAM unchanged, fetch_count=0. The first request after reset completes with normal latency.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: state encoding,
// default base address and the byte-lane mask helper.
package mem_pkg;

    // Byte address of RAM word 0; matches the core's PROGADDR_RESET.
    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h0001_0000;

    // One-hot responder states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_RESP = 3'b100
    } state_e;

    // Expand a 4-bit lane mask into a 32-bit byte mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/mem_responder_bytelane_ram.sv
// Word-organised RAM with one synchronous read port and one write port
// carrying an independent enable per byte lane.
module bytelane_ram
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 16384,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o,
    input  logic [3:0]    wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_data_q;

    // Byte-lane writes and registered read.
    // NOTE: the storage array has no reset; clearing it would need a
    // per-word reset mux and would stop it mapping onto block RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_i[i]) begin
                mem_q[wr_addr_i][8*i +: 8] <= wr_data_i[8*i +: 8];
            end
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Target end of the core's data memory port. Accepts one request at a
// time, waits a fixed number of cycles, then pulses mem_ready for one
// cycle with read data, performing any strobed write at the end of that
// cycle. Flags out-of-range accesses and address changes while waiting.
module mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int          DEPTH_WORDS = 16384,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic [3:0]  mem_rmask,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err,
    output logic        proto_err,
    output logic [31:0] fetch_count
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    // Size of the mapped window in bytes, kept at 33 bits.
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   addr_byte_q, addr_byte_d;
    logic          in_range_q, in_range_d;
    logic          instr_q, instr_d;
    logic [3:0]    rmask_q, rmask_d;
    logic          proto_err_q, proto_err_d;
    logic [31:0]   fetch_count_q, fetch_count_d;

    logic [32:0]   offset;
    logic          req_in_range;
    logic          ram_rd_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;

    // Offset from the base in 33 bits: addresses below the base set bit 32
    // and so can never compare below SPAN.
    assign offset       = {1'b0, mem_addr} - {1'b0, ADDR_BASE};
    assign req_in_range = (offset < SPAN);

    // State register and per-access latches.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            addr_byte_q   <= '0;
            in_range_q    <= 1'b0;
            instr_q       <= 1'b0;
            rmask_q       <= '0;
            proto_err_q   <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            addr_byte_q   <= addr_byte_d;
            in_range_q    <= in_range_d;
            instr_q       <= instr_d;
            rmask_q       <= rmask_d;
            proto_err_q   <= proto_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic, RAM read launch and write enables.
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        addr_byte_d   = addr_byte_q;
        in_range_d    = in_range_q;
        instr_d       = instr_q;
        rmask_d       = rmask_q;
        proto_err_d   = proto_err_q;
        fetch_count_d = fetch_count_q;
        ram_rd_en     = 1'b0;
        ram_we        = 4'b0000;

        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d      = offset[AW+1:2];
                    addr_byte_d = mem_addr;
                    in_range_d  = req_in_range;
                    instr_d     = mem_instr;
                    rmask_d     = mem_rmask;
                    cnt_d       = 4'(WAIT_STATES);
                    if (WAIT_STATES == 0) begin
                        state_d   = ST_RESP;
                        ram_rd_en = 1'b1;
                    end else begin
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_addr != addr_byte_q) begin
                    proto_err_d = 1'b1;
                end
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = ST_RESP;
                    ram_rd_en = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (instr_q) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                end
                // A reset asserted on the closing edge drops the write.
                if (resetn && in_range_q) begin
                    ram_we = mem_wstrb;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The RAM read is launched on the edge entering RESP, so its output
    // register holds the addressed word for exactly the RESP cycle.
    bytelane_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk       (clk),
        .rd_en_i   (ram_rd_en),
        .rd_addr_i (addr_d),
        .rd_data_o (ram_rdata),
        .wr_en_i   (ram_we),
        .wr_addr_i (addr_q),
        .wr_data_i (mem_wdata)
    );

    // Outputs derive from registers only; no input reaches mem_ready.
    assign mem_ready   = (state_q == ST_RESP);
    assign err         = mem_ready & ~in_range_q;
    assign mem_rdata   = (mem_ready && in_range_q) ? (ram_rdata & lane_mask(rmask_q)) : 32'h0;
    assign proto_err   = proto_err_q;
    assign fetch_count = fetch_count_q;

endmodule
